// File: rtl/spi_clk_pkg.sv
// ---------------------------------------------------------------------------
// spi_clk_pkg
// Shared definitions for the SPI serial-clock generator:
//   - default widths for the divide value and bit counter
//   - FSM state encoding (IDLE / ACTIVE)
//   - SPI mode encoding: mode = {cpol, cpha}, giving modes 0..3
// ---------------------------------------------------------------------------
package spi_clk_pkg;

    localparam int DEF_DIV_WIDTH = 8;
    localparam int DEF_CNT_WIDTH = 6;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    typedef enum logic [0:0] {
        IDLE   = ST_IDLE,
        ACTIVE = ST_ACTIVE
    } state_e;

    typedef logic [1:0] spi_mode_t;

    function automatic spi_mode_t spi_mode(input logic cpol, input logic cpha);
        return {cpol, cpha};
    endfunction

    function automatic logic mode_cpol(input spi_mode_t mode);
        return mode[1];
    endfunction

    function automatic logic mode_cpha(input spi_mode_t mode);
        return mode[0];
    endfunction

endpackage

// File: rtl/sclk_tick_gen.sv
// ---------------------------------------------------------------------------
// sclk_tick_gen
// Half-period counter: the generalised divider core. While enabled it counts
// 0..load_val and raises tick in the cycle the count equals load_val, then
// wraps to 0. A tick therefore occurs every load_val+1 enabled cycles, the
// first one load_val+1 cycles after enable rises from a cleared count.
//
// Ports:
//   clk_in    in   system clock
//   rst       in   asynchronous active-high reset
//   en        in   count enable; when low the count is held at 0
//   clr       in   synchronous clear of the count
//   load_val  in   terminal count (half-period minus one)
//   tick      out  high in the cycle the count reaches load_val
// ---------------------------------------------------------------------------
module sclk_tick_gen
    import spi_clk_pkg::*;
#(
    parameter int W = DEF_DIV_WIDTH
) (
    input  logic         clk_in,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] load_val,
    output logic         tick
);

    localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tick = en && (cnt_q == load_val);

    // The count never exceeds load_val, so an all-ones load cannot wrap early.
    always_comb begin
        cnt_d = cnt_q;
        if (!en || clr || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_sclk_gen.sv
// ---------------------------------------------------------------------------
// spi_sclk_gen
// SPI serial clock generator for one transfer of num_bits bits. Supports all
// four SPI modes and a runtime divide ratio (half-period = div_val+1 cycles).
// Provides start/busy/done handshake, abort, and one-cycle sample/shift
// strobes aligned with the sclk edge they belong to.
//
// Ports:
//   clk_in     in   system clock
//   rst        in   asynchronous active-high reset
//   div_val    in   half-period minus one, in clk_in cycles
//   cpol       in   sclk idle level
//   cpha       in   0: sample on leading edge, 1: shift on leading edge
//   num_bits   in   bits per transfer (0 is ignored)
//   start      in   request a transfer, honoured only in IDLE
//   abort      in   synchronous cancel of an active transfer
//   busy       out  transfer in progress
//   done       out  one-cycle pulse on normal completion
//   sclk       out  registered serial clock
//   sample_en  out  one-cycle strobe: capture MISO
//   shift_en   out  one-cycle strobe: drive next MOSI bit
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | sclk follows cpol, waiting for start with num_bits != 0
// ACTIVE | configuration latched, sclk toggling every div_lat+1 cycles
// ---------------------------------------------------------------------------
module spi_sclk_gen
    import spi_clk_pkg::*;
#(
    parameter int DIV_WIDTH = DEF_DIV_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic [DIV_WIDTH-1:0] div_val,
    input  logic                 cpol,
    input  logic                 cpha,
    input  logic [CNT_WIDTH-1:0] num_bits,
    input  logic                 start,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 sclk,
    output logic                 sample_en,
    output logic                 shift_en
);

    localparam logic [CNT_WIDTH:0] ECNT_ONE = {{CNT_WIDTH{1'b0}}, 1'b1};

    state_e                 state_q, state_d;
    logic [DIV_WIDTH-1:0]   div_lat_q, div_lat_d;
    logic [CNT_WIDTH-1:0]   nbits_lat_q, nbits_lat_d;
    spi_mode_t              mode_q, mode_d;
    logic [CNT_WIDTH:0]     ecnt_q, ecnt_d;
    logic                   sclk_q, sclk_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   sample_q, sample_d;
    logic                   shift_q, shift_d;

    logic                   tick;
    logic                   tick_en;
    logic                   cpol_lat;
    logic                   cpha_lat;
    logic                   edge_lead;
    logic                   edge_last;
    logic [CNT_WIDTH:0]     last_ecnt;

    assign tick_en   = (state_q == ACTIVE);
    assign cpol_lat  = mode_cpol(mode_q);
    assign cpha_lat  = mode_cpha(mode_q);

    // Edge index of the final edge is 2*N-1; even indices are leading edges.
    assign last_ecnt = {nbits_lat_q, 1'b0} - ECNT_ONE;
    assign edge_lead = ~ecnt_q[0];
    assign edge_last = (ecnt_q == last_ecnt);

    sclk_tick_gen #(
        .W (DIV_WIDTH)
    ) u_tick (
        .clk_in   (clk_in),
        .rst      (rst),
        .en       (tick_en),
        .clr      (abort),
        .load_val (div_lat_q),
        .tick     (tick)
    );

    always_comb begin
        state_d     = state_q;
        div_lat_d   = div_lat_q;
        nbits_lat_d = nbits_lat_q;
        mode_d      = mode_q;
        ecnt_d      = ecnt_q;
        sclk_d      = sclk_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        sample_d    = 1'b0;
        shift_d     = 1'b0;

        case (state_q)
            IDLE: begin
                sclk_d = cpol;
                if (start && (num_bits != '0)) begin
                    div_lat_d   = div_val;
                    nbits_lat_d = num_bits;
                    mode_d      = spi_mode(cpol, cpha);
                    ecnt_d      = '0;
                    busy_d      = 1'b1;
                    state_d     = ACTIVE;
                end
            end

            ACTIVE: begin
                // Abort wins over an edge landing in the same cycle.
                if (abort) begin
                    sclk_d  = cpol_lat;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (tick) begin
                    sclk_d = ~sclk_q;
                    ecnt_d = ecnt_q + ECNT_ONE;
                    if (cpha_lat) begin
                        shift_d  = edge_lead;
                        sample_d = ~edge_lead;
                    end else begin
                        // Bit 0 is already on MOSI, so the last trailing
                        // edge has nothing left to shift out.
                        sample_d = edge_lead;
                        shift_d  = ~edge_lead && ~edge_last;
                    end
                    if (edge_last) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            div_lat_q   <= '0;
            nbits_lat_q <= '0;
            mode_q      <= '0;
            ecnt_q      <= '0;
            sclk_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sample_q    <= 1'b0;
            shift_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_lat_q   <= div_lat_d;
            nbits_lat_q <= nbits_lat_d;
            mode_q      <= mode_d;
            ecnt_q      <= ecnt_d;
            sclk_q      <= sclk_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            sample_q    <= sample_d;
            shift_q     <= shift_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sclk      = sclk_q;
    assign sample_en = sample_q;
    assign shift_en  = shift_q;

endmodule

// File: tb/tb_spi_sclk_gen.sv
module tb_spi_sclk_gen;

    localparam int DW = 8;
    localparam int CW = 6;

    logic          clk_in = 1'b0;
    logic          rst;
    logic [DW-1:0] div_val;
    logic          cpol;
    logic          cpha;
    logic [CW-1:0] num_bits;
    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic          sclk;
    logic          sample_en;
    logic          shift_en;

    int n_cmp = 0;
    int n_err = 0;

    logic [4:0] obs_q[$];

    spi_sclk_gen #(
        .DIV_WIDTH (DW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .div_val   (div_val),
        .cpol      (cpol),
        .cpha      (cpha),
        .num_bits  (num_bits),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .sclk      (sclk),
        .sample_en (sample_en),
        .shift_en  (shift_en)
    );

    always #5 clk_in = ~clk_in;

    // Reference: outputs {busy,done,sclk,sample,shift} r cycles after the
    // clock edge that accepted start. Edge k (0-based) becomes visible at
    // r = (k+1)*hp + 1; sclk equals cpol xor parity of edges seen so far.
    function automatic logic [4:0] model_vec(input logic pol, input logic pha,
                                             input int d, input int n, input int r);
        int   hp, total, e, k;
        logic b, dn, sc, sm, sh;
        hp    = d + 1;
        total = 2 * n * hp;
        b     = (r >= 1) && (r <= total);
        dn    = (r == total + 1);
        e     = (r - 1) / hp;
        sc    = pol ^ ((e % 2) == 1);
        sm    = 1'b0;
        sh    = 1'b0;
        if (((r - 1) % hp == 0) && (e >= 1)) begin
            k = e - 1;
            if (k % 2 == 0) begin
                if (!pha) sm = 1'b1;
                else      sh = 1'b1;
            end else begin
                if (!pha) sh = (k != 2 * n - 1);
                else      sm = 1'b1;
            end
        end
        return {b, dn, sc, sm, sh};
    endfunction

    // Drives one transfer request and records outputs for r = 1 .. total+1.
    // Call and return at 1 time unit after a rising clock edge.
    task automatic run_xfer(input logic pol, input logic pha, input int d, input int n,
                            input bit keep_start, input int perturb_at);
        int         total;
        logic [31:0] rnd;
        logic [31:0] dv;
        logic [31:0] nv;
        total = 2 * n * (d + 1);
        dv = d;
        nv = n;
        obs_q.delete();
        cpol     = pol;
        cpha     = pha;
        div_val  = dv[DW-1:0];
        num_bits = nv[CW-1:0];
        start    = 1'b1;
        for (int r = 1; r <= total + 1; r++) begin
            @(posedge clk_in);
            #1;
            if (r == 1 && !keep_start) start = 1'b0;
            if (perturb_at != 0 && r == perturb_at) begin
                start    = 1'b1;
                cpol     = ~cpol;
                rnd      = $urandom;
                div_val  = rnd[DW-1:0] | 8'h10;
                rnd      = $urandom;
                num_bits = rnd[CW-1:0];
            end
            if (perturb_at != 0 && r == perturb_at + 1) start = 1'b0;
            obs_q.push_back({busy, done, sclk, sample_en, shift_en});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cpol = 1'b0; cpha = 1'b0; start = 1'b0; abort = 1'b0;
        div_val = '0; num_bits = '0;
        repeat (2) @(posedge clk_in);
        #1;
        n_cmp++;
        if ({busy, done, sclk, sample_en, shift_en} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_state got %b want 00000", {busy, done, sclk, sample_en, shift_en});
        end
        rst = 1'b0;
        @(posedge clk_in);
        #1;
        cpol = 1'b1;
        n_cmp++;
        if (sclk !== 1'b0) begin
            n_err++;
            $display("FAIL idle_cpol_before got %b want 0", sclk);
        end
        @(posedge clk_in);
        #1;
        n_cmp++;
        if (sclk !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL idle_cpol_after got sclk=%b busy=%b want sclk=1 busy=0", sclk, busy);
        end
        cpol = 1'b0;
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_mode0();
        int c_busy = 0, c_done = 0, c_samp = 0, c_shift = 0, c_bad = 0;
        logic [4:0] exp;
        run_xfer(1'b0, 1'b0, 1, 8, 1'b0, 0);
        foreach (obs_q[i]) begin
            exp = model_vec(1'b0, 1'b0, 1, 8, i + 1);
            n_cmp++;
            if (obs_q[i] !== exp) begin
                n_err++;
                $display("FAIL mode0_cycle r=%0d got %b want %b", i + 1, obs_q[i], exp);
            end
            c_busy  += int'(obs_q[i][4]);
            c_done  += int'(obs_q[i][3]);
            c_samp  += int'(obs_q[i][1]);
            c_shift += int'(obs_q[i][0]);
            if (obs_q[i][1] && !obs_q[i][2]) c_bad++;
            if (obs_q[i][0] &&  obs_q[i][2]) c_bad++;
        end
        n_cmp++;
        if (c_busy != 32 || c_done != 1) begin
            n_err++;
            $display("FAIL mode0_busy_done got busy=%0d done=%0d want 32/1", c_busy, c_done);
        end
        n_cmp++;
        if (c_samp != 8 || c_shift != 7 || c_bad != 0) begin
            n_err++;
            $display("FAIL mode0_strobes got samp=%0d shift=%0d badlvl=%0d want 8/7/0", c_samp, c_shift, c_bad);
        end
        n_cmp++;
        if (sclk !== 1'b0) begin
            n_err++;
            $display("FAIL mode0_end_sclk got %b want 0", sclk);
        end
    endtask

    task automatic test_mode3();
        int c_busy = 0, c_samp = 0, c_shift = 0, c_bad = 0;
        logic [4:0] exp;
        run_xfer(1'b1, 1'b1, 0, 3, 1'b0, 0);
        foreach (obs_q[i]) begin
            exp = model_vec(1'b1, 1'b1, 0, 3, i + 1);
            n_cmp++;
            if (obs_q[i] !== exp) begin
                n_err++;
                $display("FAIL mode3_cycle r=%0d got %b want %b", i + 1, obs_q[i], exp);
            end
            c_busy  += int'(obs_q[i][4]);
            c_samp  += int'(obs_q[i][1]);
            c_shift += int'(obs_q[i][0]);
            if (obs_q[i][1] && !obs_q[i][2]) c_bad++;
            if (obs_q[i][0] &&  obs_q[i][2]) c_bad++;
        end
        n_cmp++;
        if (c_busy != 6 || c_samp != 3 || c_shift != 3 || c_bad != 0 || sclk !== 1'b1) begin
            n_err++;
            $display("FAIL mode3_summary got busy=%0d samp=%0d shift=%0d badlvl=%0d sclk=%b want 6/3/3/0/1",
                     c_busy, c_samp, c_shift, c_bad, sclk);
        end
    endtask

    task automatic test_latch();
        int c_busy = 0, c_done = 0, c_bad = 0;
        logic [4:0] exp;
        run_xfer(1'b0, 1'b0, 2, 5, 1'b0, 8);
        foreach (obs_q[i]) begin
            exp = model_vec(1'b0, 1'b0, 2, 5, i + 1);
            n_cmp++;
            if (obs_q[i] !== exp) begin
                n_err++;
                $display("FAIL latch_cycle r=%0d got %b want %b", i + 1, obs_q[i], exp);
            end
            c_busy += int'(obs_q[i][4]);
            c_done += int'(obs_q[i][3]);
        end
        for (int i = 0; i < 12; i++) begin
            @(posedge clk_in);
            #1;
            if (busy !== 1'b0 || done !== 1'b0 || sclk !== cpol) c_bad++;
        end
        n_cmp++;
        if (c_busy != 30 || c_done != 1 || c_bad != 0) begin
            n_err++;
            $display("FAIL latch_summary got busy=%0d done=%0d idle_bad=%0d want 30/1/0", c_busy, c_done, c_bad);
        end
        cpol = 1'b0;
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp;
        for (int t = 0; t < 2; t++) begin
            run_xfer(1'b1, 1'b0, 1, 2, (t == 0), 0);
            foreach (obs_q[i]) begin
                exp = model_vec(1'b1, 1'b0, 1, 2, i + 1);
                n_cmp++;
                if (obs_q[i] !== exp) begin
                    n_err++;
                    $display("FAIL b2b_cycle xfer=%0d r=%0d got %b want %b", t, i + 1, obs_q[i], exp);
                end
            end
        end
        cpol = 1'b0;
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_abort(input int d);
        int         hp, r_abort, c_bad;
        logic [4:0] exp;
        logic [31:0] dv;
        hp = d + 1;
        r_abort = 3 * hp + 1;
        c_bad = 0;
        dv = d;
        cpol = 1'b0; cpha = 1'b1; div_val = dv[DW-1:0]; num_bits = 6'd4; start = 1'b1;
        for (int r = 1; r <= r_abort; r++) begin
            @(posedge clk_in);
            #1;
            if (r == 1) start = 1'b0;
            exp = model_vec(1'b0, 1'b1, d, 4, r);
            n_cmp++;
            if ({busy, done, sclk, sample_en, shift_en} !== exp) begin
                n_err++;
                $display("FAIL abort_pre d=%0d r=%0d got %b want %b", d, r,
                         {busy, done, sclk, sample_en, shift_en}, exp);
            end
        end
        abort = 1'b1;
        @(posedge clk_in);
        #1;
        abort = 1'b0;
        n_cmp++;
        if ({busy, done, sclk, sample_en, shift_en} !== 5'b0) begin
            n_err++;
            $display("FAIL abort_next d=%0d got %b want 00000", d, {busy, done, sclk, sample_en, shift_en});
        end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk_in);
            #1;
            if ({busy, done, sample_en, shift_en} !== 4'b0) c_bad++;
        end
        n_cmp++;
        if (c_bad != 0) begin
            n_err++;
            $display("FAIL abort_quiet d=%0d got %0d bad cycles want 0", d, c_bad);
        end
        run_xfer(1'b0, 1'b1, d, 4, 1'b0, 0);
        foreach (obs_q[i]) begin
            exp = model_vec(1'b0, 1'b1, d, 4, i + 1);
            n_cmp++;
            if (obs_q[i] !== exp) begin
                n_err++;
                $display("FAIL abort_rerun d=%0d r=%0d got %b want %b", d, i + 1, obs_q[i], exp);
            end
        end
    endtask

    task automatic test_async_reset();
        cpol = 1'b1; cpha = 1'b0; div_val = 8'd2; num_bits = 6'd6; start = 1'b1;
        @(posedge clk_in);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk_in);
        #3;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, sclk, sample_en, shift_en} !== 5'b0) begin
            n_err++;
            $display("FAIL async_reset got %b want 00000", {busy, done, sclk, sample_en, shift_en});
        end
        @(posedge clk_in);
        #3;
        rst = 1'b0;
        @(posedge clk_in);
        #1;
        n_cmp++;
        if (sclk !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL after_reset got sclk=%b busy=%b done=%b want 1/0/0", sclk, busy, done);
        end
        cpol = 1'b0;
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_zero_bits();
        int c_bad = 0;
        cpol = 1'b1; cpha = 1'b0; div_val = 8'd1; num_bits = 6'd0; start = 1'b1;
        @(posedge clk_in);
        #1;
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (busy !== 1'b0 || done !== 1'b0 || sclk !== 1'b1) c_bad++;
            if (i == 5) start = 1'b1;
            @(posedge clk_in);
            #1;
        end
        start = 1'b0;
        n_cmp++;
        if (c_bad != 0) begin
            n_err++;
            $display("FAIL zero_bits got %0d bad cycles want 0", c_bad);
        end
        cpol = 1'b0;
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_boundaries();
        logic [4:0] exp;
        logic [31:0] rnd;
        rnd = $urandom;
        run_xfer(rnd[0], rnd[1], 255, 1, 1'b0, 0);
        foreach (obs_q[i]) begin
            exp = model_vec(rnd[0], rnd[1], 255, 1, i + 1);
            n_cmp++;
            if (obs_q[i] !== exp) begin
                n_err++;
                $display("FAIL maxdiv r=%0d got %b want %b", i + 1, obs_q[i], exp);
            end
        end
        run_xfer(rnd[2], rnd[3], 0, 63, 1'b0, 0);
        foreach (obs_q[i]) begin
            exp = model_vec(rnd[2], rnd[3], 0, 63, i + 1);
            n_cmp++;
            if (obs_q[i] !== exp) begin
                n_err++;
                $display("FAIL maxbits r=%0d got %b want %b", i + 1, obs_q[i], exp);
            end
        end
        cpol = 1'b0;
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_random();
        logic [4:0]  exp;
        logic [31:0] rnd;
        int          d, n, gap, c_bad;
        logic        pol, pha;
        c_bad = 0;
        for (int t = 0; t < 25; t++) begin
            rnd = $urandom;
            pol = rnd[0];
            pha = rnd[1];
            d   = $urandom_range(6, 0);
            n   = $urandom_range(9, 1);
            gap = $urandom_range(3, 0);
            run_xfer(pol, pha, d, n, 1'b0, 0);
            foreach (obs_q[i]) begin
                exp = model_vec(pol, pha, d, n, i + 1);
                n_cmp++;
                if (obs_q[i] !== exp) begin
                    n_err++;
                    $display("FAIL random t=%0d mode=%0d d=%0d n=%0d r=%0d got %b want %b",
                             t, {pol, pha}, d, n, i + 1, obs_q[i], exp);
                end
            end
            for (int g = 0; g < gap; g++) begin
                @(posedge clk_in);
                #1;
                if (busy !== 1'b0 || done !== 1'b0 || sclk !== pol) c_bad++;
            end
        end
        n_cmp++;
        if (c_bad != 0) begin
            n_err++;
            $display("FAIL random_idle got %0d bad idle cycles want 0", c_bad);
        end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode3();
        test_latch();
        test_back_to_back();
        test_abort(1);
        test_abort(0);
        test_async_reset();
        test_zero_bits();
        test_boundaries();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spi_sclk_gen.md
Name: spi_sclk_gen

Overview:
Parametrised successor to the fixed-factor clock divider. Generates the SPI serial clock (SCLK) for one transfer of a programmable number of bits. Divide ratio is runtime-programmable, and all four SPI modes (CPOL/CPHA) are supported. Provides start/busy/done handshake, an abort, and single-cycle sample/shift strobes for the SPI master's shift register.

Parameters:
DIV_WIDTH, 8, width of div_val; half-period = div_val+1 clk_in cycles
CNT_WIDTH, 6, width of num_bits; max transfer 2^CNT_WIDTH-1 bits

Ports:
clk_in  input  1  system clock; sole clock of the block
rst  input  1  asynchronous, active-high reset
div_val  input  DIV_WIDTH  half-period minus one, in clk_in cycles
cpol  input  1  SCLK idle level
cpha  input  1  0: sample on leading edge; 1: shift on leading edge
num_bits  input  CNT_WIDTH  bits per transfer; 0 = invalid
start  input  1  request transfer; honoured only in IDLE
abort  input  1  synchronous cancel of active transfer
busy  output  1  transfer in progress
done  output  1  one-cycle pulse on normal completion
sclk  output  1  registered serial clock
sample_en  output  1  one-cycle strobe: capture MISO
shift_en  output  1  one-cycle strobe: drive next MOSI bit

Behaviour:
- One clock (clk_in). Reset is asynchronous and active-high (rst). All outputs are registered.
- Reset values: sclk=0, busy=0, done=0, sample_en=0, shift_en=0, state=IDLE, counters=0. Reset mid-transfer takes effect immediately: no done pulse, and the transfer is lost.
- States are IDLE and ACTIVE.
- IDLE:
  - sclk <= cpol each cycle, so cpol changes appear one cycle later.
  - On start=1 with num_bits!=0: latch div_val, cpol, cpha and num_bits; hcnt<=0; ecnt<=0; busy<=1; go ACTIVE.
  - start with num_bits=0 is ignored: no busy, no done.
- ACTIVE:
  - hcnt counts 0..div_lat. When hcnt==div_lat, an edge occurs: sclk toggles, hcnt<=0, ecnt<=ecnt+1. ecnt is CNT_WIDTH+1 bits wide.
  - First edge appears div_lat+1 cycles after busy rises. SCLK period is 2*(div_lat+1). div_val=0 gives clk_in/2.
  - Edges with even ecnt (0,2,...) are leading; edges with odd ecnt are trailing.
  - cpha=0: sample_en on every leading edge; shift_en on every trailing edge except the last. Bit 0 is driven by the master before start.
  - cpha=1: shift_en on every leading edge; sample_en on every trailing edge.
  - Strobes assert in the same cycle the new sclk value appears.
  - Final edge (ecnt==2*N-1) returns sclk to cpol. In that same cycle: busy<=0, done<=1, state<=IDLE.
  - busy is high for exactly 2*N*(div_lat+1) cycles.
  - abort=1: state<=IDLE, sclk<=cpol_lat, busy<=0, no strobes, no done. abort in IDLE has no effect. abort has priority over an edge falling in the same cycle.
- start while busy is ignored. Input changes while ACTIVE have no effect because configuration is latched.
- done and start in the same cycle: busy is already 0 when start is seen, so a new transfer may begin on the cycle after done. There is no back-to-back overlap.
- div_lat at its maximum (all ones) must not overflow hcnt; hcnt is DIV_WIDTH bits wide.

Decomposition:
- Package spi_clk_pkg contains:
  - state enum {IDLE, ACTIVE}
  - default DIV_WIDTH and CNT_WIDTH constants
  - the mode encoding (CPOL/CPHA to mode 0-3)
- One sub-module, sclk_tick_gen: a half-period counter with enable, load value and a tick output. It is the generalised divider core. Edge counting, mode logic and handshake stay in the top level.

Test Plan:
- Mode 0, div_val=1, num_bits=8, start pulse:
  - busy high 32 cycles; sclk idles 0 with period 4.
  - 8 sample_en pulses on rising sclk; 7 shift_en pulses on falling sclk.
  - done one cycle coincident with the 16th edge; sclk ends 0.
- Mode 3, div_val=0, num_bits=3:
  - sclk idles 1 with period 2; busy high 6 cycles.
  - 3 shift_en on falling edges, 3 sample_en on rising edges; sclk ends 1.
- num_bits=5, div_val=2, then start re-pulsed plus changed div_val/cpol mid-transfer:
  - busy exactly 30 cycles; period stays 6; no second transfer.
  - done exactly once.
- abort asserted after the 3rd edge (mode 1, num_bits=4):
  - next cycle sclk=0, busy=0; no done and no further strobes.
  - a subsequent start runs a full clean transfer.
- rst asserted asynchronously mid-transfer (cpol=1):
  - sclk=0, busy=0, strobes=0 immediately.
  - after release sclk=1 on the next clk_in edge.
- start with num_bits=0: busy, done and sclk unchanged for 20 cycles.
